// File: rtl/btb_pkg.sv
// Shared BTB definitions: 128-bit two-way set layout, predictor encodings
// and the update-side FSM state type.
package btb_pkg;

  localparam int SET_W = 128;
  localparam int TAG_W = 27;
  localparam int IDX_W = 3;
  localparam int TGT_W = 32;

  // Way1 occupies the upper half of the set, way2 the lower half.
  localparam int W1_VALID  = 127;
  localparam int W1_TAG_LO = 100;
  localparam int W1_TGT_LO = 68;
  localparam int W1_FSM_LO = 66;
  localparam int W2_VALID  = 63;
  localparam int W2_TAG_LO = 36;
  localparam int W2_TGT_LO = 4;
  localparam int W2_FSM_LO = 2;

  // LRU names the victim: 0 = way1, 1 = way2.
  localparam int LRU_BIT = 64;

  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] WT  = 2'b10;
  localparam logic [1:0] ST  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_MODIFY = 2'd1,
    S_WRITE  = 2'd2
  } upd_state_e;

endpackage

// File: rtl/btb_update_logic_sat_counter.sv
// Combinational 2-bit saturating predictor trainer (next state from the
// current state and the resolved direction).
module btb_sat_counter
  import btb_pkg::*;
(
  input  logic [1:0] i_fsm,
  input  logic       i_taken,
  output logic [1:0] o_fsm_next
);

  always_comb begin
    o_fsm_next = i_fsm;
    case (i_fsm)
      SNT:     o_fsm_next = i_taken ? WNT : SNT;
      WNT:     o_fsm_next = i_taken ? WT  : SNT;
      WT:      o_fsm_next = i_taken ? ST  : WNT;
      ST:      o_fsm_next = i_taken ? ST  : WT;
      default: o_fsm_next = i_fsm;
    endcase
  end

endmodule

// File: rtl/btb_update_logic.sv
// BTB update path: read-modify-write of one two-way set per resolved branch.
// Optional statistics counters are enabled with `define BTB_UPD_STATS_EN.
module btb_update_logic
  import btb_pkg::*;
#(
  parameter logic [1:0] INIT_FSM = 2'b10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 upd_valid,
  output logic                 upd_ready,
  input  logic [31:0]          upd_pc,
  input  logic                 upd_taken,
  input  logic [TGT_W-1:0]     upd_target,
  output logic                 rd_en,
  output logic [IDX_W-1:0]     rd_index,
  input  logic [SET_W-1:0]     rd_data,
  output logic                 wr_en,
  output logic [IDX_W-1:0]     wr_index,
  output logic [SET_W-1:0]     wr_data,
`ifdef BTB_UPD_STATS_EN
  output logic [31:0]          stat_upd,
  output logic [31:0]          stat_alloc,
  output logic [31:0]          stat_hit,
`endif
  output logic [1:0]           dbg_state,
  output logic                 upd_done
);

  // Handshake: a request transfers on a rising edge where upd_valid and
  // upd_ready are both high; the requester holds its fields until then.

  upd_state_e            r_state;
  upd_state_e            w_state_next;
  logic [TAG_W-1:0]      r_tag;
  logic [IDX_W-1:0]      r_idx;
  logic                  r_taken;
  logic [TGT_W-1:0]      r_target;
  logic [IDX_W-1:0]      r_wr_index;
  logic [SET_W-1:0]      r_wr_data;

  logic                  w_accept;
  logic                  w_capture;
  logic                  w_v1;
  logic                  w_v2;
  logic                  w_hit1;
  logic                  w_hit2;
  logic                  w_hit;
  logic                  w_victim2;
  logic [1:0]            w_fsm_sel;
  logic [1:0]            w_fsm_trained;
  logic [SET_W-1:0]      w_new_set;
  logic                  w_unused;

  assign w_unused  = &{1'b0, upd_pc[1:0]};
  assign rd_index  = upd_pc[4:2];
  assign wr_index  = r_wr_index;
  assign wr_data   = r_wr_data;
  assign dbg_state = r_state;

  assign w_v1   = rd_data[W1_VALID];
  assign w_v2   = rd_data[W2_VALID];
  assign w_hit1 = w_v1 && (rd_data[W1_TAG_LO +: TAG_W] == r_tag);
  assign w_hit2 = w_v2 && (rd_data[W2_TAG_LO +: TAG_W] == r_tag) && !w_hit1;
  assign w_hit  = w_hit1 || w_hit2;
  // Fill an invalid way first (way1 preferred), otherwise follow LRU.
  assign w_victim2 = w_v1 && (!w_v2 || rd_data[LRU_BIT]);

  assign w_fsm_sel = w_hit1 ? rd_data[W1_FSM_LO +: 2] : rd_data[W2_FSM_LO +: 2];

  btb_sat_counter u_sat (
    .i_fsm      (w_fsm_sel),
    .i_taken    (r_taken),
    .o_fsm_next (w_fsm_trained)
  );

  always_comb begin
    w_new_set = rd_data;
    if (w_hit1) begin
      w_new_set[W1_FSM_LO +: 2] = w_fsm_trained;
      if (r_taken) w_new_set[W1_TGT_LO +: TGT_W] = r_target;
      w_new_set[LRU_BIT] = 1'b1;
    end else if (w_hit2) begin
      w_new_set[W2_FSM_LO +: 2] = w_fsm_trained;
      if (r_taken) w_new_set[W2_TGT_LO +: TGT_W] = r_target;
      w_new_set[LRU_BIT] = 1'b0;
    end else if (w_victim2) begin
      w_new_set[W2_VALID]               = 1'b1;
      w_new_set[W2_TAG_LO +: TAG_W]     = r_tag;
      w_new_set[W2_TGT_LO +: TGT_W]     = r_target;
      w_new_set[W2_FSM_LO +: 2]         = INIT_FSM;
      w_new_set[LRU_BIT]                = 1'b0;
    end else begin
      w_new_set[W1_VALID]               = 1'b1;
      w_new_set[W1_TAG_LO +: TAG_W]     = r_tag;
      w_new_set[W1_TGT_LO +: TGT_W]     = r_target;
      w_new_set[W1_FSM_LO +: 2]         = INIT_FSM;
      w_new_set[LRU_BIT]                = 1'b1;
    end
  end

  always_comb begin
    w_state_next = r_state;
    upd_ready    = 1'b0;
    rd_en        = 1'b0;
    wr_en        = 1'b0;
    upd_done     = 1'b0;
    w_accept     = 1'b0;
    w_capture    = 1'b0;
    case (r_state)
      S_IDLE: begin
        upd_ready = 1'b1;
        if (upd_valid) begin
          rd_en        = 1'b1;
          w_accept     = 1'b1;
          w_state_next = S_MODIFY;
        end
      end
      S_MODIFY: begin
        if (w_hit || r_taken) begin
          w_capture    = 1'b1;
          w_state_next = S_WRITE;
        end else begin
          upd_done     = 1'b1;
          w_state_next = S_IDLE;
        end
      end
      S_WRITE: begin
        wr_en        = 1'b1;
        upd_done     = 1'b1;
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
    // Reset silences every strobe in the same cycle, so an in-flight
    // update never reaches the set memory.
    if (rst) begin
      upd_ready    = 1'b0;
      rd_en        = 1'b0;
      wr_en        = 1'b0;
      upd_done     = 1'b0;
      w_accept     = 1'b0;
      w_capture    = 1'b0;
      w_state_next = S_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_tag      <= '0;
      r_idx      <= '0;
      r_taken    <= 1'b0;
      r_target   <= '0;
      r_wr_index <= '0;
      r_wr_data  <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_tag    <= upd_pc[31:5];
        r_idx    <= upd_pc[4:2];
        r_taken  <= upd_taken;
        r_target <= upd_target;
      end
      if (w_capture) begin
        r_wr_index <= r_idx;
        r_wr_data  <= w_new_set;
      end
    end
  end

`ifdef BTB_UPD_STATS_EN
  logic        r_alloc;
  logic [31:0] r_stat_upd;
  logic [31:0] r_stat_alloc;
  logic [31:0] r_stat_hit;

  assign stat_upd   = r_stat_upd;
  assign stat_alloc = r_stat_alloc;
  assign stat_hit   = r_stat_hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_alloc      <= 1'b0;
      r_stat_upd   <= '0;
      r_stat_alloc <= '0;
      r_stat_hit   <= '0;
    end else begin
      if (w_capture) r_alloc <= !w_hit;
      if (upd_done) r_stat_upd <= r_stat_upd + 32'd1;
      if (wr_en && r_alloc) r_stat_alloc <= r_stat_alloc + 32'd1;
      if (wr_en && !r_alloc) r_stat_hit <= r_stat_hit + 32'd1;
    end
  end
`endif

endmodule

// File: doc/btb_update_logic.md
# btb_update_logic

Write-side companion of the two-way BTB set lookup. It accepts resolved-branch updates from the execute stage and performs a read-modify-write of one 128-bit BTB set. On a hit it trains the 2-bit predictor and refreshes the target. On a taken miss it allocates a way. It sits between the execute-stage branch unit and the BTB set memory, and reuses the exact set layout that the fetch-side lookup decodes.

## Interface
- `INIT_FSM`, default 2'b10: predictor state written into a newly allocated way.

Ports:
- `clk` input 1: clock.
- `rst` input 1: reset, synchronous and active-high.
- `upd_valid` input 1: update request valid.
- `upd_ready` output 1: block can accept a request.
- `upd_pc` input 32: branch PC. Index is `upd_pc[4:2]`; tag is `upd_pc[31:5]`.
- `upd_taken` input 1: resolved direction.
- `upd_target` input 32: resolved target.
- `rd_en` output 1: set-memory read strobe.
- `rd_index` output 3: read set index.
- `rd_data` input 128: set contents, valid one cycle after `rd_en`.
- `wr_en` output 1: set-memory write strobe.
- `wr_index` output 3: write set index.
- `wr_data` output 128: full set written.
- `upd_done` output 1: one-cycle pulse when a request retires, with or without a write.

## Operation
- Set layout:
  - Way1: valid [127], tag [126:100], target [99:68], fsm [67:66].
  - Way2: valid [63], tag [62:36], target [35:4], fsm [3:2].
  - LRU bit [64]. 0 = way1 is the victim; 1 = way2 is the victim.
  - Bits [65], [1:0] are preserved unchanged.
- FSM states: IDLE, MODIFY, WRITE.
- IDLE:
  - `upd_ready`=1.
  - On `upd_valid`: latch pc/taken/target, drive `rd_en`=1 with `rd_index`=`upd_pc[4:2]` combinationally, then go to MODIFY.
- MODIFY:
  - Decode `rd_data`. hit1 = valid1 && tag match; hit2 = valid2 && tag match. hit1 has priority if both match.
  - Hit: saturating-train that way's fsm: taken → +1 up to 11; not-taken → −1 down to 00. If taken, overwrite that way's target. Set LRU to point at the other way. Go to WRITE.
  - Miss and taken: pick the victim.
    - Way1 if invalid, else way2 if invalid, else the way named by LRU.
    - Write valid=1, tag, target, fsm=`INIT_FSM` into the victim. Set LRU to the other way. Go to WRITE.
  - Miss and not-taken: no allocation. Pulse `upd_done` and go to IDLE.
- WRITE:
  - `wr_en`=1, with `wr_index`/`wr_data` driven from registers.
  - Pulse `upd_done` and go to IDLE.
- The non-targeted way is copied bit-exact.
- Reset values: state IDLE; `rd_en`, `wr_en`, `upd_done`, `upd_ready` all 0 while `rst` is high; index and data registers 0.

## Timing
- Request accepted at cycle 0. `rd_en` is high in cycle 0.
- MODIFY is cycle 1. WRITE is cycle 2, with `wr_en` and `upd_done` high.
- `upd_ready` is high again in cycle 3. Peak throughput is one update per 3 cycles.
- Not-taken miss: `upd_done` in cycle 1, ready in cycle 2, no write.
- `upd_valid` with `upd_ready`=0 is ignored. The requester holds the request until the handshake completes.
- `rst` asserted in MODIFY or WRITE aborts the update: no `wr_en` in the following cycle.
- `rd_en` and `wr_en` are never high in the same cycle.

## Configuration
- `BTB_UPD_STATS_EN` defined: adds outputs `stat_upd` [31:0], `stat_alloc` [31:0] and `stat_hit` [31:0].
  - All three counters reset to 0 and wrap modulo 2^32.
  - `stat_upd` increments on each `upd_done`.
  - `stat_alloc` increments on each allocation write.
  - `stat_hit` increments on each hit write.
- `BTB_UPD_STATS_EN` undefined: these ports and counters do not exist. All other behaviour is identical.

## Structure
- Shared package `btb_pkg` holds:
  - Way bit-position constants.
  - `LRU_BIT`=64.
  - Tag width 27, index width 3.
  - FSM encodings `SNT`=00, `WNT`=01, `WT`=10, `ST`=11.
  - The update FSM state enum.
- One sub-module, `btb_sat_counter`: combinational 2-bit saturating next-state function with inputs fsm and taken.

## Test plan
- Empty set (`rd_data`=0), pc=0x0000_1234, taken=1, target=0x0000_8000 → `wr_index`=5, `wr_data[127]`=1, tag=0x91, target=0x8000, fsm=10, `wr_data[64]`=1.
- Way2 hit with fsm=11, taken=1 → fsm stays 11, `wr_data[64]`=0, way1 bits unchanged.
- Way1 hit with fsm=00, not-taken → fsm stays 00, target unchanged, write still occurs.
- Both ways valid, miss, LRU=1, taken → way2 replaced, LRU becomes 0.
- Miss with not-taken → `upd_done` in cycle 1, `wr_en` never asserted, `upd_ready` back in cycle 2.
- `rst` pulsed during MODIFY → no `wr_en`; `upd_ready`=1 the cycle after reset deasserts.
